// File: rtl/ifetch_pkg.sv
// Shared opcodes, FSM state encoding and prefetch-queue entry layout for the fetch unit.
// Entry fields are sized for the default 32-bit PC/instruction; the top casts into and out of them.
package ifetch_pkg;

    localparam logic [6:0] OPC_B   = 7'b1100000;
    localparam logic [6:0] OPC_NOP = 7'b1100100;

    localparam int FE_PC_W    = 32;
    localparam int FE_INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        UCODE = 2'd2
    } state_t;

    typedef struct packed {
        logic [FE_PC_W-1:0]    pc;
        logic [FE_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the pushed entry is visible at the head the cycle after the push.
// Push is ignored when full unless a pop happens in the same cycle; flush overrides push and pop.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_dat,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_head_dat,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    logic w_do_push;
    logic w_do_pop;

    assign o_full     = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty    = (r_cnt == '0);
    assign o_count    = r_cnt;
    assign o_head_dat = r_mem[r_rp];

    // A pop frees the head slot in the same cycle, so a push into a full FIFO is safe then.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + AW'(1);
            if (w_do_pop)  r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wp] <= i_push_dat;
    end

endmodule

// File: rtl/ifetch_pq.sv
// Fetch unit: one outstanding imem request, B/NOP predecode, prefetch queue to decode; redirects flush via epoch.
// Response enqueued the cycle it arrives, visible to decode next cycle; issue stalls on full queue or ucode.
module ifetch_pq import ifetch_pkg::*; #(
    parameter int          XLEN     = 32,
    parameter int          ILEN     = 32,
    parameter int          IMM_W    = 16,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter bit          DROP_NOP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [ILEN-1:0]  imem_resp_data,
    input  logic             redir_rel_valid,
    input  logic [XLEN-1:0]  redir_rel_pc,
    input  logic [IMM_W-1:0] redir_rel_off,
    input  logic             redir_abs_valid,
    input  logic [XLEN-1:0]  redir_abs_target,
    input  logic             ucode_busy,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [ILEN-1:0]  dec_instr,
    output logic [XLEN-1:0]  dec_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = $bits(fetch_entry_t);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_epoch;
    logic            r_inflight;
    logic            r_tag;
    logic [XLEN-1:0] r_resp_pc;
    logic            r_hold;
    logic [XLEN-1:0] r_hold_addr;
    logic            r_hold_epoch;

    logic            w_can_issue;
    logic            w_req_epoch;
    logic            w_req_acc;
    logic            w_redir;
    logic [XLEN-1:0] w_redir_tgt;
    logic            w_resp_live;
    logic            w_resp_ok;
    logic [6:0]      w_opc;
    logic            w_is_b;
    logic            w_is_nop;
    logic [XLEN-1:0] w_resp_next;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_push_ent;
    fetch_entry_t    w_head;
    logic [EW-1:0]   w_head_dat;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = RUN;
            RUN:     if (ucode_busy)  w_state_nxt = UCODE;
            UCODE:   if (!ucode_busy) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A request that was offered but not accepted keeps its address and epoch until the handshake.
    assign w_can_issue    = (r_state == RUN) && !r_hold && !r_inflight && (w_count < CW'(DEPTH));
    assign imem_req_valid = r_hold || w_can_issue;
    assign imem_req_addr  = r_hold ? r_hold_addr : r_fetch_pc;
    assign w_req_epoch    = r_hold ? r_hold_epoch : r_epoch;
    assign w_req_acc      = imem_req_valid && imem_req_ready;

    assign w_redir     = (r_state != IDLE) && (redir_rel_valid || redir_abs_valid);
    assign w_redir_tgt = redir_rel_valid
                       ? redir_rel_pc + {{(XLEN-IMM_W){redir_rel_off[IMM_W-1]}}, redir_rel_off}
                       : redir_abs_target;

    assign w_resp_live = imem_resp_valid && r_inflight;
    assign w_resp_ok   = w_resp_live && (r_tag == r_epoch) && !w_redir;
    assign w_opc       = imem_resp_data[ILEN-1 -: 7];
    assign w_is_b      = (w_opc == OPC_B);
    assign w_is_nop    = (w_opc == OPC_NOP) && DROP_NOP;
    assign w_resp_next = w_is_b
                       ? r_resp_pc + {{(XLEN-IMM_W){imem_resp_data[IMM_W-1]}}, imem_resp_data[IMM_W-1:0]}
                       : r_resp_pc + XLEN'(4);

    assign w_push           = w_resp_ok && !w_is_nop && (!w_full || w_pop);
    assign w_pop            = dec_valid && dec_ready;
    assign w_push_ent.pc    = FE_PC_W'(r_resp_pc);
    assign w_push_ent.instr = FE_INSTR_W'(imem_resp_data);
    assign w_head           = w_head_dat;

    assign dec_valid = (r_state == RUN) && !w_empty;
    assign dec_instr = dec_valid ? ILEN'(w_head.instr) : '0;
    assign dec_pc    = dec_valid ? XLEN'(w_head.pc)    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_fetch_pc   <= XLEN'(RESET_PC);
            r_epoch      <= 1'b0;
            r_inflight   <= 1'b0;
            r_tag        <= 1'b0;
            r_resp_pc    <= '0;
            r_hold       <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_epoch <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_resp_live) r_inflight <= 1'b0;
            if (w_req_acc) begin
                r_inflight <= 1'b1;
                r_tag      <= w_req_epoch;
                r_resp_pc  <= imem_req_addr;
                r_hold     <= 1'b0;
            end else if (imem_req_valid) begin
                r_hold       <= 1'b1;
                r_hold_addr  <= imem_req_addr;
                r_hold_epoch <= w_req_epoch;
            end
            if (w_redir) begin
                r_fetch_pc <= w_redir_tgt;
                r_epoch    <= !r_epoch;
            end else if (w_resp_ok) begin
                r_fetch_pc <= w_resp_next;
            end
        end
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .i_flush    (w_redir),
        .o_head_dat (w_head_dat),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

endmodule

// File: doc/ifetch_pq.md
Name: ifetch_pq

Overview:
- Parametrised instruction fetch unit with a prefetch queue.
- Issues word fetches to instruction memory over a valid/ready request channel, accepting variable-latency responses.
- Predecodes unconditional B and NOP opcodes, buffers instructions with their PCs, and delivers them to decode over a valid/ready handshake.
- Handles relative and absolute redirects from EXE (stale-response discard via an epoch bit) and freezes delivery while the microcode sequencer owns the pipeline.

Parameters:
- XLEN, 32, PC and address width
- ILEN, 32, instruction width
- IMM_W, 16, branch offset width; sign-extended to XLEN
- DEPTH, 4, prefetch queue entries; power of 2, ≥2
- RESET_PC, 0, fetch PC after reset
- DROP_NOP, 1, 1 = NOPs consumed in fetch and never enqueued

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  XLEN  fetch byte address
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  response valid; exactly one per accepted request
- imem_resp_data  in  ILEN  fetched instruction
- redir_rel_valid  in  1  EXE relative redirect
- redir_rel_pc  in  XLEN  PC of redirecting instruction
- redir_rel_off  in  IMM_W  signed byte offset
- redir_abs_valid  in  1  EXE absolute (register) redirect
- redir_abs_target  in  XLEN  absolute target
- ucode_busy  in  1  microcode sequencer active
- dec_valid  out  1  instruction available
- dec_ready  in  1  decode accepts
- dec_instr  out  ILEN  instruction
- dec_pc  out  XLEN  its PC

Behaviour:
- Reset (synchronous, active-high, clk):
  - state=IDLE, fetch_pc=RESET_PC, queue empty, no outstanding request, epoch=0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0.
  - rst mid-operation discards the queue and any outstanding response; a response arriving after reset is ignored.
- States:
  - IDLE→RUN the first cycle rst=0.
  - RUN→UCODE when ucode_busy=1.
  - UCODE→RUN when ucode_busy=0.
  - No other transitions.
- Issue:
  - imem_req_valid=1 in RUN when no request is outstanding and count<DEPTH.
  - At most one request outstanding.
  - Once asserted, valid and addr hold stable until imem_req_ready.
  - On acceptance, the unit latches the request PC and the current epoch as tag.
- Response:
  - A response whose tag≠epoch is dropped.
  - Otherwise the opcode is bits [ILEN-1:ILEN-7]:
    - 7'b1100000 (B): enqueue; fetch_pc=resp_pc+sext(imm[IMM_W-1:0]).
    - 7'b1100100 (NOP) with DROP_NOP=1: not enqueued; fetch_pc=resp_pc+4.
    - Other opcodes: enqueue; fetch_pc=resp_pc+4.
  - Arithmetic is modulo 2^XLEN and wraps silently.
- Queue:
  - FIFO of {pc,instr}.
  - dec_valid=!empty in RUN; forced 0 in IDLE/UCODE.
  - Head is registered: a response enqueued at edge N is visible at edge N+1.
  - Simultaneous enqueue and dequeue is legal at any count.
  - Overflow cannot occur because issue is gated on count<DEPTH with at most one outstanding.
- Redirect:
  - If both redirects are asserted, rel wins: target=redir_rel_pc+sext(redir_rel_off); otherwise abs target.
  - In the redirect cycle: queue flushed, fetch_pc=target, epoch toggles.
  - A decode handshake in that same cycle completes; everything else in the queue is discarded.
  - A response arriving in the redirect cycle, or later with the old tag, is dropped.
  - A pending unaccepted request still completes at its old address and is dropped by tag.
  - The first request to the target follows in the next cycle it is legal.
- UCODE:
  - No new requests are issued; an outstanding response is still accepted into the queue.
  - Queue contents and fetch_pc are held.
  - Redirects are applied in UCODE and the state stays UCODE.
- Latency: the earliest cycle a response can be enqueued is the cycle after request acceptance; dec_valid follows one cycle after enqueue.

Decomposition:
- ifetch_pkg holds:
  - OPC_B=7'b1100000 and OPC_NOP=7'b1100100
  - the state enum {IDLE,RUN,UCODE}
  - the fetch_entry_t struct {pc,instr}
- Sub-module fetch_fifo: parametrised synchronous FIFO with push, pop, flush, full/empty, and count outputs.

Test Plan:
- Reset, then memory returns ADD words with 1-cycle latency and dec_ready=1 → requests to 0,4,8,12; dec_pc sequence 0,4,8,12; no bubbles beyond one request in flight.
- B at 0x10 with imm=0x0020 → next request to 0x30; B itself delivered with dec_pc=0x10. B with imm=0xFFF0 at 0x10 → next request to 0x00.
- NOP at 0x8 with DROP_NOP=1 → dec_pc skips 0x8; next request to 0xC.
- dec_ready=0 for 10 cycles → queue fills to DEPTH=4; imem_req_valid stays 0; no entry is lost when ready returns.
- Redirect with a response outstanding (rel pc=0x40, off=0x8, plus abs=0x100 in the same cycle) → stale response dropped; queue flushed; next request to 0x48.
- ucode_busy=1 for 5 cycles with one request outstanding → response enqueued, dec_valid=0, no new requests; ucode_busy=0 → delivery resumes in order.
